// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with load-use bubble insertion, flush and external stall
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALUOP_WIDTH    = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      ext_stall,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rd,
  input  logic                      if_id_uses_rt,
  input  logic                      ctl_reg_write,
  input  logic                      ctl_mem_to_reg,
  input  logic                      ctl_mem_read,
  input  logic                      ctl_mem_write,
  input  logic                      ctl_alu_src,
  input  logic                      ctl_reg_dst,
  input  logic [ALUOP_WIDTH-1:0]    ctl_alu_op,
  input  logic [DATA_WIDTH-1:0]     read_data_1,
  input  logic [DATA_WIDTH-1:0]     read_data_2,
  input  logic [DATA_WIDTH-1:0]     sign_ext_imm,
  input  logic [DATA_WIDTH-1:0]     pc_plus4,
  output logic                      id_ex_reg_write,
  output logic                      id_ex_mem_to_reg,
  output logic                      id_ex_mem_read,
  output logic                      id_ex_mem_write,
  output logic                      id_ex_alu_src,
  output logic                      id_ex_reg_dst,
  output logic [ALUOP_WIDTH-1:0]    id_ex_alu_op,
  output logic [DATA_WIDTH-1:0]     id_ex_read_data_1,
  output logic [DATA_WIDTH-1:0]     id_ex_read_data_2,
  output logic [DATA_WIDTH-1:0]     id_ex_imm,
  output logic [DATA_WIDTH-1:0]     id_ex_pc_plus4,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_instr_rs,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_instr_rt,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_instr_rd,
  output logic                      id_ex_valid,
  output logic                      hazard_stall,
  output logic [CNT_WIDTH-1:0]      bubble_count
);
  localparam int PW = 7 + ALUOP_WIDTH + 4 * DATA_WIDTH + 3 * REG_ADDR_WIDTH;
  logic [PW-1:0]        r_q;
  logic [PW-1:0]        w_d;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_lu;
  logic                 w_bubble;
  assign w_d = {1'b1, ctl_reg_write, ctl_mem_to_reg, ctl_mem_read, ctl_mem_write, ctl_alu_src,
                ctl_reg_dst, ctl_alu_op, read_data_1, read_data_2, sign_ext_imm, pc_plus4,
                if_id_rs, if_id_rt, if_id_rd};
  assign {id_ex_valid, id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write,
          id_ex_alu_src, id_ex_reg_dst, id_ex_alu_op, id_ex_read_data_1, id_ex_read_data_2,
          id_ex_imm, id_ex_pc_plus4, id_ex_instr_rs, id_ex_instr_rt, id_ex_instr_rd} = r_q;
  // A load into $0 never creates a dependency.
  assign w_lu = id_ex_mem_read & id_ex_valid & (id_ex_instr_rt != '0) &
                ((id_ex_instr_rt == if_id_rs) | (if_id_uses_rt & (id_ex_instr_rt == if_id_rt)));
  assign hazard_stall = w_lu & ~flush;
  assign w_bubble     = flush | (w_lu & ~ext_stall);
  assign bubble_count = r_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= '0;
    else if (w_bubble) r_q <= '0;
    else if (!ext_stall) r_q <= w_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else if (w_lu & ~flush & ~ext_stall & ~&r_cnt) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed load-use, stall, flush, saturation and async reset checks
module tb_id_ex_pipe_reg;
  localparam int DW = 32, RW = 5, AW = 4, CW = 2;
  logic clk = 0, reset = 1, flush = 0, ext_stall = 0;
  logic [RW-1:0] if_id_rs = 0, if_id_rt = 0, if_id_rd = 0;
  logic if_id_uses_rt = 0;
  logic ctl_reg_write = 0, ctl_mem_to_reg = 0, ctl_mem_read = 0, ctl_mem_write = 0, ctl_alu_src = 0, ctl_reg_dst = 0;
  logic [AW-1:0] ctl_alu_op = 0;
  logic [DW-1:0] read_data_1 = 0, read_data_2 = 0, sign_ext_imm = 0, pc_plus4 = 0;
  logic id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src, id_ex_reg_dst;
  logic [AW-1:0] id_ex_alu_op;
  logic [DW-1:0] id_ex_read_data_1, id_ex_read_data_2, id_ex_imm, id_ex_pc_plus4;
  logic [RW-1:0] id_ex_instr_rs, id_ex_instr_rt, id_ex_instr_rd;
  logic id_ex_valid, hazard_stall;
  logic [CW-1:0] bubble_count;
  int checks = 0, errors = 0;

  id_ex_pipe_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .ALUOP_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ext_stall(ext_stall),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rd(if_id_rd), .if_id_uses_rt(if_id_uses_rt),
    .ctl_reg_write(ctl_reg_write), .ctl_mem_to_reg(ctl_mem_to_reg), .ctl_mem_read(ctl_mem_read),
    .ctl_mem_write(ctl_mem_write), .ctl_alu_src(ctl_alu_src), .ctl_reg_dst(ctl_reg_dst),
    .ctl_alu_op(ctl_alu_op), .read_data_1(read_data_1), .read_data_2(read_data_2),
    .sign_ext_imm(sign_ext_imm), .pc_plus4(pc_plus4),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_alu_src(id_ex_alu_src), .id_ex_reg_dst(id_ex_reg_dst),
    .id_ex_alu_op(id_ex_alu_op), .id_ex_read_data_1(id_ex_read_data_1), .id_ex_read_data_2(id_ex_read_data_2),
    .id_ex_imm(id_ex_imm), .id_ex_pc_plus4(id_ex_pc_plus4), .id_ex_instr_rs(id_ex_instr_rs),
    .id_ex_instr_rt(id_ex_instr_rt), .id_ex_instr_rd(id_ex_instr_rd), .id_ex_valid(id_ex_valid),
    .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic [4:0] rs, rt, rd, input logic urt, mr, mw, rw, input logic [3:0] op, input logic [31:0] pc);
    if_id_rs = rs; if_id_rt = rt; if_id_rd = rd; if_id_uses_rt = urt;
    ctl_mem_read = mr; ctl_mem_to_reg = mr; ctl_alu_src = mr | mw; ctl_mem_write = mw;
    ctl_reg_write = rw; ctl_reg_dst = ~mr & rw; ctl_alu_op = op;
    read_data_1 = 32'h1000 + pc; read_data_2 = 32'h2000 + pc; sign_ext_imm = 32'h4; pc_plus4 = pc;
    #1;
  endtask

  initial begin
    #2;
    check("rst_valid", id_ex_valid, 0);
    check("rst_cnt", bubble_count, 0);
    check("rst_hazard", hazard_stall, 0);
    step();
    reset = 0;
    // lw $8, 4($2) then add $9,$8,$10
    id(2, 8, 0, 0, 1, 0, 1, 0, 32'h40);
    step();
    check("lw_memread", id_ex_mem_read, 1);
    check("lw_rt", id_ex_instr_rt, 8);
    check("lw_valid", id_ex_valid, 1);
    check("lw_rd1", id_ex_read_data_1, 32'h1040);
    check("lw_imm", id_ex_imm, 4);
    id(8, 10, 9, 1, 0, 0, 1, 2, 32'h44);
    check("add_hazard", hazard_stall, 1);
    step();
    check("bub_valid", id_ex_valid, 0);
    check("bub_regwrite", id_ex_reg_write, 0);
    check("bub_rt", id_ex_instr_rt, 0);
    check("bub_cnt", bubble_count, 1);
    check("bub_hazard", hazard_stall, 0);
    step();
    check("add_valid", id_ex_valid, 1);
    check("add_rs", id_ex_instr_rs, 8);
    check("add_rd", id_ex_instr_rd, 9);
    check("add_aluop", id_ex_alu_op, 2);
    check("add_pc", id_ex_pc_plus4, 32'h44);
    // lw $8 then sw $8 through rt
    id(2, 8, 0, 0, 1, 0, 1, 0, 32'h48);
    step();
    id(3, 8, 0, 1, 0, 1, 0, 0, 32'h4c);
    check("sw_hazard", hazard_stall, 1);
    step();
    check("sw_bub_valid", id_ex_valid, 0);
    check("sw_bub_cnt", bubble_count, 2);
    step();
    check("sw_memwrite", id_ex_mem_write, 1);
    check("sw_rt", id_ex_instr_rt, 8);
    // lw $8 then an instruction that does not read rt
    id(2, 8, 0, 0, 1, 0, 1, 0, 32'h50);
    step();
    id(3, 8, 0, 0, 0, 0, 1, 1, 32'h54);
    check("nort_hazard", hazard_stall, 0);
    step();
    check("nort_valid", id_ex_valid, 1);
    check("nort_cnt", bubble_count, 2);
    // lw $0 then add using $0
    id(1, 0, 0, 0, 1, 0, 1, 0, 32'h58);
    step();
    id(0, 0, 7, 1, 0, 0, 1, 2, 32'h5c);
    check("r0_hazard", hazard_stall, 0);
    step();
    check("r0_valid", id_ex_valid, 1);
    check("r0_cnt", bubble_count, 2);
    // load-use under a 3-cycle external stall
    id(2, 8, 0, 0, 1, 0, 1, 0, 32'h60);
    step();
    id(8, 10, 9, 1, 0, 0, 1, 2, 32'h64);
    ext_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_memread", id_ex_mem_read, 1);
      check("stl_pc", id_ex_pc_plus4, 32'h60);
      check("stl_hazard", hazard_stall, 1);
      check("stl_cnt", bubble_count, 2);
    end
    ext_stall = 0;
    step();
    check("stl_bub_valid", id_ex_valid, 0);
    check("stl_bub_cnt", bubble_count, 3);
    step();
    check("stl_add_valid", id_ex_valid, 1);
    check("stl_add_rs", id_ex_instr_rs, 8);
    check("stl_cnt_once", bubble_count, 3);
    // flush with a pending load-use
    id(2, 8, 0, 0, 1, 0, 1, 0, 32'h70);
    step();
    id(8, 10, 9, 1, 0, 0, 1, 2, 32'h74);
    flush = 1;
    #1;
    check("fl_hazard", hazard_stall, 0);
    step();
    flush = 0;
    check("fl_valid", id_ex_valid, 0);
    check("fl_pc", id_ex_pc_plus4, 0);
    check("fl_cnt", bubble_count, 3);
    // saturation: counter already at all-ones
    id(2, 8, 0, 0, 1, 0, 1, 0, 32'h80);
    step();
    id(8, 10, 9, 1, 0, 0, 1, 2, 32'h84);
    check("sat_hazard", hazard_stall, 1);
    step();
    check("sat_valid", id_ex_valid, 0);
    check("sat_cnt", bubble_count, 3);
    // asynchronous reset between edges with a load in EX
    id(2, 8, 0, 0, 1, 0, 1, 0, 32'h90);
    step();
    id(8, 10, 9, 1, 0, 0, 1, 2, 32'h94);
    check("pre_rst_hazard", hazard_stall, 1);
    #1 reset = 1;
    #1;
    check("arst_valid", id_ex_valid, 0);
    check("arst_memread", id_ex_mem_read, 0);
    check("arst_rd1", id_ex_read_data_1, 0);
    check("arst_rt", id_ex_instr_rt, 0);
    check("arst_cnt", bubble_count, 0);
    check("arst_hazard", hazard_stall, 0);
    step();
    reset = 0;
    step();
    check("post_rst_valid", id_ex_valid, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection. Latches decoded control, operands and register specifiers from ID every cycle. Drives EX-stage datapath and the forwarding unit (id_ex_instr_rs/rt). Inserts a one-cycle bubble and stalls PC/IF-ID when an EX-stage load feeds the instruction in ID; honours branch flush and external stall.

Parameters:
DATA_WIDTH, 32, operand / immediate / PC width
REG_ADDR_WIDTH, 5, register specifier width
ALUOP_WIDTH, 4, ALU operation code width
CNT_WIDTH, 16, bubble counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
flush  in  1  branch/jump taken; squash instruction entering EX
ext_stall  in  1  downstream (memory) stall; hold register contents
if_id_rs  in  REG_ADDR_WIDTH  rs of instruction in ID
if_id_rt  in  REG_ADDR_WIDTH  rt of instruction in ID
if_id_rd  in  REG_ADDR_WIDTH  rd of instruction in ID
if_id_uses_rt  in  1  ID instruction reads rt as source (R-type, sw, beq)
ctl_reg_write, ctl_mem_to_reg, ctl_mem_read, ctl_mem_write, ctl_alu_src, ctl_reg_dst  in  1 each  decoded control
ctl_alu_op  in  ALUOP_WIDTH  decoded ALU op
read_data_1, read_data_2, sign_ext_imm, pc_plus4  in  DATA_WIDTH each  ID datapath values
id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src, id_ex_reg_dst  out  1 each  registered control
id_ex_alu_op  out  ALUOP_WIDTH  registered ALU op
id_ex_read_data_1, id_ex_read_data_2, id_ex_imm, id_ex_pc_plus4  out  DATA_WIDTH each  registered datapath
id_ex_instr_rs, id_ex_instr_rt, id_ex_instr_rd  out  REG_ADDR_WIDTH each  registered specifiers (to forwarding unit)
id_ex_valid  out  1  EX holds a real instruction (0 = bubble)
hazard_stall  out  1  combinational; deassert PC write and IF/ID write
bubble_count  out  CNT_WIDTH  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, any time incl. mid-stall): every registered output = 0; bubble_count = 0; id_ex_valid = 0. hazard_stall then 0 (depends on id_ex_mem_read).
- Load-use detect (combinational): lu = id_ex_mem_read & id_ex_valid & (id_ex_instr_rt != 0) & ((id_ex_instr_rt == if_id_rs) | (if_id_uses_rt & id_ex_instr_rt == if_id_rt)).
- hazard_stall = lu & ~flush. Flush discards the ID instruction, so no stall is needed.
- Per rising edge, priority highest first:
  1. flush: load bubble. All control outputs 0, id_ex_valid = 0, specifiers 0, data 0.
  2. ext_stall: hold every register unchanged (bubble_count unchanged).
  3. lu: load bubble as in 1; bubble_count += 1, saturating at all-ones.
  4. else: load all ctl_* / data / if_id_* inputs, id_ex_valid = 1.
- ext_stall & lu together: hold. hazard_stall stays 1 because EX still holds the load, so IF/ID also holds. The bubble is inserted on the first non-stalled edge; counted once.
- Latency: 1 cycle ID→EX. Exactly one bubble per load-use pair; the forwarding unit resolves the remaining MEM/WB distance.
- Bubble specifiers are 0, so a bubble never matches forwarding (reg 0 excluded).
- Load to $0 (rt = 0) never stalls.
- bubble_count wraps never; it holds at 2^CNT_WIDTH-1.

Test Plan:
- Reset mid-operation: assert reset with valid loaded state, async between edges → all outputs 0 immediately, bubble_count 0.
- lw $8 then add $9,$8,$10 (if_id_rs=8): edge1 loads lw (mem_read=1, rt=8) → hazard_stall=1; edge2 bubble (valid=0, reg_write=0), bubble_count=1, hazard_stall=0; edge3 add loaded, rs=8.
- lw $8 then sw $8 using rt (if_id_uses_rt=1, if_id_rt=8) → one bubble. Same with if_id_uses_rt=0 → no stall, count unchanged.
- lw $0 followed by add using $0 → hazard_stall=0, no bubble.
- Load-use with ext_stall=1 for 3 cycles → outputs held, hazard_stall=1 throughout; bubble on release edge, bubble_count +1 only.
- flush=1 with load-use pending → hazard_stall=0, bubble loaded, count unchanged. Preload count to 0xFFFF, then one load-use → stays 0xFFFF.
